// File: rtl/alu_seq.sv
// alu_seq: control-side sequencer for the 8-bit ALU.
// Decodes an ALU instruction byte {1, op[2:0], ra[1:0], rb[1:0]} and runs
// three execute steps: S4 loads TMP from RB, S5 drives the ALU and loads ACC
// and the flags, and S6 writes ACC back to RB. CMP (op=111) skips the write-back.
// It owns the {C, A, E, Z} flags register.
// Optional feature macro: ALU_SEQ_CLF_EN adds CLF (bir[7:4]=0110), which
// clears the flags from IDLE and pulses wdone once.
module alu_seq #(
    parameter int NREG = 4
) (
    input  logic            wclk,
    input  logic            wrst_n,
    input  logic            wstart,
    input  logic [7:0]      bir,
    input  logic            wco,
    input  logic            walo,
    input  logic            weqo,
    input  logic            wz,
    output logic [2:0]      bops,
    output logic            wci,
    output logic [NREG-1:0] bena_reg,
    output logic [NREG-1:0] bset_reg,
    output logic            wset_tmp,
    output logic            wset_acc,
    output logic            wena_acc,
    output logic            wbusy,
    output logic            wdone,
    output logic [3:0]      bflags
);

    typedef enum logic [1:0] {IDLE, S4, S5, S6} state_t;

    localparam logic [2:0] OP_CMP = 3'b111;

    state_t     state, state_nxt;
    logic [2:0] op;
    logic [1:0] ra, rb;
    logic       accept;
    logic       clf_done;

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = (state == IDLE) && wstart && bir[7];

    // State register; synchronous reset returns to IDLE and aborts any instruction.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge wclk) begin
        if (!wrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Latch the decoded instruction fields on accept; they hold until the next accept.
    // NOTE: these fields carry no reset because they are only read in S4-S6,
    // which can be reached only through an accept that loads them.
    always_ff @(posedge wclk) begin
        if (accept) begin
            op <= bir[6:4];
            ra <= bir[3:2];
            rb <= bir[1:0];
        end
    end

`ifdef ALU_SEQ_CLF_EN
    logic clf_hit;
    assign clf_hit = (state == IDLE) && wstart && (bir[7:4] == 4'b0110);

    // Flags capture the ALU outputs at the end of S5; CLF clears them from IDLE.
    always_ff @(posedge wclk) begin
        if (!wrst_n)          bflags <= 4'b0000;
        else if (state == S5) bflags <= {wco, walo, weqo, wz};
        else if (clf_hit)     bflags <= 4'b0000;
    end

    // One-cycle done pulse following an accepted CLF.
    always_ff @(posedge wclk) begin
        if (!wrst_n) clf_done <= 1'b0;
        else         clf_done <= clf_hit;
    end
`else
    // Flags capture the ALU outputs at the end of S5.
    always_ff @(posedge wclk) begin
        if (!wrst_n)          bflags <= 4'b0000;
        else if (state == S5) bflags <= {wco, walo, weqo, wz};
    end

    assign clf_done = 1'b0;
`endif

    // Next-state logic and strobes decoded from the state and the latched fields.
    // NOTE: every output gets a default before the case so that no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        bops      = 3'b000;
        wci       = 1'b0;
        bena_reg  = '0;
        bset_reg  = '0;
        wset_tmp  = 1'b0;
        wset_acc  = 1'b0;
        wena_acc  = 1'b0;
        wbusy     = 1'b0;
        wdone     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = S4;
                wdone = clf_done;
            end
            S4: begin
                bena_reg  = onehot(rb);
                wset_tmp  = 1'b1;
                wbusy     = 1'b1;
                state_nxt = S5;
            end
            S5: begin
                bena_reg  = onehot(ra);
                bops      = op;
                wci       = bflags[3];
                wset_acc  = 1'b1;
                wbusy     = 1'b1;
                state_nxt = S6;
            end
            S6: begin
                wena_acc  = 1'b1;
                wbusy     = 1'b1;
                wdone     = 1'b1;
                bset_reg  = (op == OP_CMP) ? '0 : onehot(rb);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// Each issued instruction pushes its expected per-cycle outputs (S4, S5, S6, IDLE)
// onto a scoreboard queue. Every following cycle pops one entry and compares it.
// The CLF checks follow ALU_SEQ_CLF_EN when the bench is compiled.
module tb_alu_seq;

    typedef struct packed {
        logic [2:0] bops;
        logic       wci;
        logic [3:0] bena_reg;
        logic [3:0] bset_reg;
        logic       wset_tmp;
        logic       wset_acc;
        logic       wena_acc;
        logic       wbusy;
        logic       wdone;
    } outs_t;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       wstart = 1'b0;
    logic [7:0] bir = 8'h00;
    logic       wco = 1'b0, walo = 1'b0, weqo = 1'b0, wz = 1'b0;
    logic [2:0] bops;
    logic       wci;
    logic [3:0] bena_reg, bset_reg;
    logic       wset_tmp, wset_acc, wena_acc, wbusy, wdone;
    logic [3:0] bflags;

    int    errors = 0;
    int    checks = 0;
    outs_t exp_q[$];
    logic [3:0] exp_flags = 4'b0000;

    alu_seq #(.NREG(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .wstart(wstart), .bir(bir),
        .wco(wco), .walo(walo), .weqo(weqo), .wz(wz),
        .bops(bops), .wci(wci), .bena_reg(bena_reg), .bset_reg(bset_reg),
        .wset_tmp(wset_tmp), .wset_acc(wset_acc), .wena_acc(wena_acc),
        .wbusy(wbusy), .wdone(wdone), .bflags(bflags)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic outs_t actual();
        outs_t o;
        o = '{bops, wci, bena_reg, bset_reg, wset_tmp, wset_acc, wena_acc, wbusy, wdone};
        return o;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0000;
        v[i] = 1'b1;
        return v;
    endfunction

    // Pop one expected entry and compare it with this cycle's outputs.
    task automatic pop_cmp(input string tag);
        outs_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(actual()), 32'(e));
        end
    endtask

    // Drive an instruction in IDLE and push its four expected cycles.
    task automatic issue(input logic [7:0] b, input logic [3:0] alu);
        outs_t e;
        logic [2:0] op;
        op = b[6:4];
        e = '0; e.bena_reg = oh(b[1:0]); e.wset_tmp = 1'b1; e.wbusy = 1'b1;
        exp_q.push_back(e);
        e = '0; e.bena_reg = oh(b[3:2]); e.bops = op; e.wci = exp_flags[3];
        e.wset_acc = 1'b1; e.wbusy = 1'b1;
        exp_q.push_back(e);
        e = '0; e.wena_acc = 1'b1; e.wbusy = 1'b1; e.wdone = 1'b1;
        e.bset_reg = (op == 3'b111) ? 4'b0000 : oh(b[1:0]);
        exp_q.push_back(e);
        exp_q.push_back('0);
        wstart = 1'b1;
        bir = b;
        {wco, walo, weqo, wz} = alu;
    endtask

    // Step through S4..IDLE; optionally hold wstart and scramble bir during execution.
    task automatic run(input string tag, input logic [3:0] alu, input bit hold);
        tick();
        if (hold) bir = 8'h00;
        else wstart = 1'b0;
        pop_cmp({tag, "_s4"});
        tick();
        pop_cmp({tag, "_s5"});
        tick();
        exp_flags = alu;
        pop_cmp({tag, "_s6"});
        check({tag, "_flags"}, 32'(bflags), 32'(exp_flags));
        tick();
        pop_cmp({tag, "_idle"});
    endtask

    initial begin
        tick();
        tick();
        wrst_n = 1'b1;
        check("reset_outs", 32'(actual()), 32'd0);
        check("reset_flags", 32'(bflags), 32'd0);

        // Set all flags, then reset and confirm they clear.
        issue(8'h92, 4'b1111);
        run("set1111", 4'b1111, 1'b0);
        wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1;
        exp_flags = 4'b0000;
        check("rst_flags", 32'(bflags), 32'd0);
        check("rst_outs", 32'(actual()), 32'd0);

        // Set C=1, then ADD R0,R1 must see wci=1 in S5.
        issue(8'h93, 4'b1000);
        run("setc", 4'b1000, 1'b0);
        issue(8'h81, 4'b0100);
        run("add", 4'b0100, 1'b0);

        // CMP: no write-back, flags capture 0011.
        issue(8'hF6, 4'b0011);
        run("cmp", 4'b0011, 1'b0);

        // wstart held high, bir scrambled after accept; next accept only from IDLE.
        issue(8'hA5, 4'b0101);
        run("hold1", 4'b0101, 1'b1);
        issue(8'hA5, 4'b1010);
        run("hold2", 4'b1010, 1'b1);
        wstart = 1'b0;
        tick();
        check("hold_idle", 32'(actual()), 32'd0);

        // CLF with flags at 1010.
        wstart = 1'b1;
        bir = 8'h60;
        tick();
        wstart = 1'b0;
`ifdef ALU_SEQ_CLF_EN
        exp_flags = 4'b0000;
        check("clf_outs", 32'(actual()), 32'd1);
`else
        check("clf_outs", 32'(actual()), 32'd0);
`endif
        check("clf_flags", 32'(bflags), 32'(exp_flags));
        check("clf_busy", 32'(wbusy), 32'd0);
        tick();
        check("clf_after", 32'(actual()), 32'd0);
        check("clf_flags2", 32'(bflags), 32'(exp_flags));

        // Reset during S5 of ADD: no flag capture, no write-back, IDLE next.
        issue(8'h81, 4'b1111);
        tick();
        wstart = 1'b0;
        pop_cmp("abort_s4");
        tick();
        pop_cmp("abort_s5");
        wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1;
        exp_q.delete();
        exp_flags = 4'b0000;
        check("abort_outs", 32'(actual()), 32'd0);
        check("abort_flags", 32'(bflags), 32'd0);
        tick();
        check("abort_idle", 32'(actual()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
